// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: sequences the PLL reset, waits for a stable lock and only then releases
// the system reset. Lock loss from RUN drops the system reset and re-enters acquisition; a lock
// timeout retries the PLL reset, and once the retry budget is spent the block parks in a sticky
// failure state until rst_n.
//
// Ports:
//   clk_tb     supervisor clock, free-running and independent of the PLL outputs
//   rst_n      asynchronous active-low reset
//   pll_lock   raw PLL lock, asynchronous to clk_tb
//   pll_rst    PLL reset, active high
//   sys_rst_n  system reset for the PLL clock consumers, active low, high only in RUN
//   lock_ok    high while in RUN
//   loss_evt   one-cycle pulse when lock is lost from RUN
//   loss_cnt   saturating count of loss-of-lock events
//   retry_cnt  PLL reset retries since the last RUN entry
//   err        sticky failure flag
module pll_lock_supervisor #(
  parameter int unsigned RST_PULSE_CYC   = 16,
  parameter int unsigned LOCK_TIMEOUT    = 4096,
  parameter int unsigned LOCK_STABLE_CYC = 64,
  parameter int unsigned MAX_RETRY       = 3,
  parameter int unsigned CNT_W           = 8,
  localparam int unsigned RETRY_W        = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic               clk_tb,
  input  logic               rst_n,
  input  logic               pll_lock,
  output logic               pll_rst,
  output logic               sys_rst_n,
  output logic               lock_ok,
  output logic               loss_evt,
  output logic [CNT_W-1:0]   loss_cnt,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic               err
);

  localparam int unsigned MaxA   = (RST_PULSE_CYC > LOCK_TIMEOUT) ? RST_PULSE_CYC : LOCK_TIMEOUT;
  localparam int unsigned MaxCyc = (MaxA > LOCK_STABLE_CYC) ? MaxA : LOCK_STABLE_CYC;
  localparam int unsigned CntW   = ($clog2(MaxCyc) < 1) ? 1 : $clog2(MaxCyc);

  localparam logic [CntW-1:0] RstLast     = CntW'(RST_PULSE_CYC - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(LOCK_TIMEOUT - 1);
  // The WAIT_LOCK cycle that first sees lock_s high is the first of the stable cycles, so STABLE
  // itself only needs LOCK_STABLE_CYC-1 more.
  localparam logic [CntW-1:0] StableLast  =
      CntW'((LOCK_STABLE_CYC >= 2) ? (LOCK_STABLE_CYC - 2) : 0);
  localparam logic [RETRY_W-1:0] RetryMax = RETRY_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    StRstPll,
    StWaitLock,
    StStable,
    StRun,
    StFail
  } state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [RETRY_W-1:0]  retry_q, retry_d;
  logic [CNT_W-1:0]    loss_cnt_q, loss_cnt_d;
  logic                loss_evt_d;
  logic [1:0]          sync_q;
  logic                lock_s;
  logic                pll_rst_q, sys_rst_n_q, lock_ok_q, loss_evt_q, err_q;

  // Two-flop synchronizer for the asynchronous lock input.
  always_ff @(posedge clk_tb or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], pll_lock};
    end
  end

  assign lock_s = sync_q[1];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    retry_d    = retry_q;
    loss_cnt_d = loss_cnt_q;
    loss_evt_d = 1'b0;

    unique case (state_q)
      StRstPll: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == RstLast) begin
          state_d = StWaitLock;
        end
      end
      StWaitLock: begin
        cnt_d = cnt_q + 1'b1;
        if (lock_s) begin
          if (LOCK_STABLE_CYC < 2) begin
            state_d = StRun;
          end else begin
            state_d = StStable;
          end
        end else if (cnt_q == TimeoutLast) begin
          if (retry_q == RetryMax) begin
            state_d = StFail;
          end else begin
            retry_d = retry_q + 1'b1;
            state_d = StRstPll;
          end
        end
      end
      StStable: begin
        cnt_d = cnt_q + 1'b1;
        if (!lock_s) begin
          state_d = StWaitLock;
        end else if (cnt_q == StableLast) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (!lock_s) begin
          state_d    = StWaitLock;
          loss_evt_d = 1'b1;
          if (loss_cnt_q != '1) begin
            loss_cnt_d = loss_cnt_q + 1'b1;
          end
        end
      end
      StFail: begin
        // Terminal; only rst_n leaves this state.
      end
      default: begin
        state_d = StRstPll;
      end
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end
    if ((state_d == StRun) && (state_q != StRun)) begin
      retry_d = '0;
    end
  end

  always_ff @(posedge clk_tb or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StRstPll;
      cnt_q      <= '0;
      retry_q    <= '0;
      loss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      loss_cnt_q <= loss_cnt_d;
    end
  end

  // Outputs are registered from the next state so they toggle cleanly on the same edge the state
  // changes, with no decode glitches.
  always_ff @(posedge clk_tb or negedge rst_n) begin
    if (!rst_n) begin
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      lock_ok_q   <= 1'b0;
      loss_evt_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      pll_rst_q   <= (state_d == StRstPll);
      sys_rst_n_q <= (state_d == StRun);
      lock_ok_q   <= (state_d == StRun);
      loss_evt_q  <= loss_evt_d;
      err_q       <= (state_d == StFail);
    end
  end

  assign pll_rst   = pll_rst_q;
  assign sys_rst_n = sys_rst_n_q;
  assign lock_ok   = lock_ok_q;
  assign loss_evt  = loss_evt_q;
  assign loss_cnt  = loss_cnt_q;
  assign retry_cnt = retry_q;
  assign err       = err_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with RST_PULSE_CYC=4, LOCK_TIMEOUT=32,
// LOCK_STABLE_CYC=8, MAX_RETRY=2 and CNT_W=2.
module tb_pll_lock_supervisor;

  logic       clk_tb;
  logic       rst_n;
  logic       pll_lock;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       lock_ok;
  logic       loss_evt;
  logic [1:0] loss_cnt;
  logic [1:0] retry_cnt;
  logic       err;

  int checks = 0;
  int errors = 0;

  pll_lock_supervisor #(
    .RST_PULSE_CYC  (4),
    .LOCK_TIMEOUT   (32),
    .LOCK_STABLE_CYC(8),
    .MAX_RETRY      (2),
    .CNT_W          (2)
  ) dut (
    .clk_tb   (clk_tb),
    .rst_n    (rst_n),
    .pll_lock (pll_lock),
    .pll_rst  (pll_rst),
    .sys_rst_n(sys_rst_n),
    .lock_ok  (lock_ok),
    .loss_evt (loss_evt),
    .loss_cnt (loss_cnt),
    .retry_cnt(retry_cnt),
    .err      (err)
  );

  initial clk_tb = 1'b0;
  always #5 clk_tb = ~clk_tb;

  task automatic tick;
    @(posedge clk_tb);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Cycles that pll_rst remains high, counted from now.
  task automatic count_pll_rst(output int n);
    n = 0;
    while (pll_rst === 1'b1 && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_sys(output int n);
    n = 0;
    while (sys_rst_n !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset;
    int n;
    rst_n = 1'b1;
    pll_lock = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({pll_rst, sys_rst_n, lock_ok, loss_evt, err} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 10000", {pll_rst, sys_rst_n, lock_ok, loss_evt, err});
    end
    checks++;
    if ({loss_cnt, retry_cnt} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_counts: got %b want 0000", {loss_cnt, retry_cnt});
    end
    tick();
    tick();
    rst_n = 1'b1;
    count_pll_rst(n);
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL reset_pulse_len: got %0d want 4", n);
    end
  endtask

  task automatic test_glitch;
    int n;
    logic early;
    early = 1'b0;
    repeat (10) tick();
    pll_lock = 1'b1;
    repeat (5) begin
      tick();
      if (sys_rst_n !== 1'b0) early = 1'b1;
    end
    pll_lock = 1'b0;
    tick();
    if (sys_rst_n !== 1'b0) early = 1'b1;
    pll_lock = 1'b1;
    wait_sys(n);
    checks++;
    if (early !== 1'b0) begin
      errors++;
      $display("FAIL glitch_early_release: got %b want 0", early);
    end
    checks++;
    if (n !== 10) begin
      errors++;
      $display("FAIL glitch_release_delay: got %0d want 10", n);
    end
    checks++;
    if (loss_cnt !== 2'd0) begin
      errors++;
      $display("FAIL glitch_loss_cnt: got %0d want 0", loss_cnt);
    end
  endtask

  task automatic test_nominal;
    int n;
    pll_lock = 1'b0;
    do_reset();
    count_pll_rst(n);
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL nominal_pulse_len: got %0d want 4", n);
    end
    repeat (10) tick();
    pll_lock = 1'b1;
    wait_sys(n);
    checks++;
    if (n !== 10) begin
      errors++;
      $display("FAIL nominal_release_delay: got %0d want 10", n);
    end
    checks++;
    if ({lock_ok, err, pll_rst, retry_cnt} !== 5'b10000) begin
      errors++;
      $display("FAIL nominal_status: got %b want 10000", {lock_ok, err, pll_rst, retry_cnt});
    end
  endtask

  task automatic test_loss_run;
    int n;
    int pulses;
    int first;
    logic rst_seen;
    pulses = 0;
    first = -1;
    rst_seen = 1'b0;
    pll_lock = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (loss_evt === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
      end
      if (pll_rst !== 1'b0) rst_seen = 1'b1;
    end
    checks++;
    if (first !== 3) begin
      errors++;
      $display("FAIL loss_evt_time: got %0d want 3", first);
    end
    checks++;
    if ({sys_rst_n, lock_ok, loss_cnt} !== 4'b0001) begin
      errors++;
      $display("FAIL loss_state: got %b want 0001", {sys_rst_n, lock_ok, loss_cnt});
    end
    pll_lock = 1'b1;
    n = 0;
    while (sys_rst_n !== 1'b1 && n < 100) begin
      tick();
      n++;
      if (pll_rst !== 1'b0) rst_seen = 1'b1;
      if (loss_evt === 1'b1) pulses++;
    end
    checks++;
    if (n !== 10) begin
      errors++;
      $display("FAIL loss_restore_delay: got %0d want 10", n);
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL loss_evt_pulses: got %0d want 1", pulses);
    end
    checks++;
    if (rst_seen !== 1'b0) begin
      errors++;
      $display("FAIL loss_pll_rst_pulse: got %b want 0", rst_seen);
    end
  endtask

  task automatic test_saturation;
    int n;
    int exp_cnt;
    for (int k = 2; k <= 5; k++) begin
      exp_cnt = (k > 3) ? 3 : k;
      pll_lock = 1'b0;
      n = 0;
      while (loss_evt !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
      checks++;
      if (n !== 3) begin
        errors++;
        $display("FAIL sat_evt_delay_%0d: got %0d want 3", k, n);
      end
      checks++;
      if (loss_cnt !== 2'(exp_cnt)) begin
        errors++;
        $display("FAIL sat_loss_cnt_%0d: got %0d want %0d", k, loss_cnt, exp_cnt);
      end
      pll_lock = 1'b1;
      wait_sys(n);
      checks++;
      if (n !== 10) begin
        errors++;
        $display("FAIL sat_relock_%0d: got %0d want 10", k, n);
      end
    end
  endtask

  task automatic test_timeout;
    logic prev;
    int npulse, hi, s2, s3, erri;
    logic [1:0] r2, r3;
    prev = 1'b1;
    npulse = 1;
    hi = 1;
    s2 = -1;
    s3 = -1;
    erri = -1;
    r2 = 2'd0;
    r3 = 2'd0;
    pll_lock = 1'b0;
    do_reset();
    for (int i = 1; i <= 200; i++) begin
      if (i == 150) pll_lock = 1'b1;
      tick();
      if (pll_rst === 1'b1 && prev === 1'b0) begin
        npulse++;
        if (npulse == 2) begin
          s2 = i;
          r2 = retry_cnt;
        end
        if (npulse == 3) begin
          s3 = i;
          r3 = retry_cnt;
        end
      end
      if (pll_rst === 1'b1) hi++;
      prev = pll_rst;
      if (err === 1'b1 && erri < 0) erri = i;
    end
    checks++;
    if (npulse !== 3 || hi !== 12) begin
      errors++;
      $display("FAIL timeout_pulses: got %0d pulses %0d high want 3 pulses 12 high", npulse, hi);
    end
    checks++;
    if (s2 !== 36 || s3 !== 72) begin
      errors++;
      $display("FAIL timeout_spacing: got %0d,%0d want 36,72", s2, s3);
    end
    checks++;
    if (r2 !== 2'd1 || r3 !== 2'd2) begin
      errors++;
      $display("FAIL timeout_retry_cnt: got %0d,%0d want 1,2", r2, r3);
    end
    checks++;
    if (erri !== 108) begin
      errors++;
      $display("FAIL timeout_err_time: got %0d want 108", erri);
    end
    checks++;
    if ({err, pll_rst, sys_rst_n, lock_ok} !== 4'b1000) begin
      errors++;
      $display("FAIL fail_sticky: got %b want 1000", {err, pll_rst, sys_rst_n, lock_ok});
    end
  endtask

  task automatic test_async_reset;
    int n;
    pll_lock = 1'b0;
    do_reset();
    n = 0;
    while (!(retry_cnt === 2'd1 && pll_rst === 1'b0) && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 40) begin
      errors++;
      $display("FAIL async_reach_wait: got %0d want 40", n);
    end
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({pll_rst, retry_cnt, err, sys_rst_n} !== 5'b10000) begin
      errors++;
      $display("FAIL async_reset_now: got %b want 10000", {pll_rst, retry_cnt, err, sys_rst_n});
    end
    #2 rst_n = 1'b1;
    count_pll_rst(n);
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL async_restart_pulse: got %0d want 4", n);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_glitch();
    test_nominal();
    test_loss_run();
    test_saturation();
    test_timeout();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
